// File: rtl/simframe_pktgen.sv
// simframe_pktgen: seed-driven frame generator with packet framing, incrementing mode and frame counting
module simframe_pktgen #(
  parameter int PATTERN_WIDTH = 32,
  parameter int OUTPUT_WIDTH  = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              FRAME_SIZE,
  input  logic [31:0]              PACKET_SIZE,
  input  logic                     MODE,
  input  logic [PATTERN_WIDTH-1:0] AXIS_IN_TDATA,
  input  logic                     AXIS_IN_TVALID,
  output logic                     AXIS_IN_TREADY,
  output logic [OUTPUT_WIDTH-1:0]  AXIS_OUT_TDATA,
  output logic                     AXIS_OUT_TVALID,
  output logic                     AXIS_OUT_TLAST,
  output logic                     AXIS_OUT_TUSER,
  input  logic                     AXIS_OUT_TREADY,
  output logic                     start_of_frame,
  output logic [31:0]              frames_sent,
  output logic                     busy
);
  localparam int LANES = OUTPUT_WIDTH / PATTERN_WIDTH;
  localparam logic [31:0] OUT_BYTES = 32'(OUTPUT_WIDTH / 8);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                   r_state;
  logic                     r_valid, r_last, r_user, r_mode;
  logic [PATTERN_WIDTH-1:0] r_base;
  logic [OUTPUT_WIDTH-1:0]  r_data;
  logic [31:0]              r_frame_rem, r_pkt_rem, r_bpp, r_frames;
  logic [31:0]              w_fq, w_pq, w_bpf, w_bpp, w_frame_nx, w_pkt_nx;
  logic [PATTERN_WIDTH-1:0] w_base_nx;
  logic                     w_hs, w_eof, w_acc;
  function automatic logic [OUTPUT_WIDTH-1:0] gen(input logic [PATTERN_WIDTH-1:0] b, input logic m);
    logic [OUTPUT_WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++)
      d[k*PATTERN_WIDTH +: PATTERN_WIDTH] = m ? b + PATTERN_WIDTH'(k) : b;
    return d;
  endfunction
  assign w_fq       = FRAME_SIZE / OUT_BYTES;
  assign w_pq       = PACKET_SIZE / OUT_BYTES;
  assign w_bpf      = (w_fq == 0) ? 32'd1 : w_fq;
  assign w_bpp      = (w_pq == 0 || w_pq >= w_bpf) ? w_bpf : w_pq;
  assign w_hs       = r_valid & AXIS_OUT_TREADY;
  assign w_eof      = w_hs & (r_frame_rem == 0);
  assign w_acc      = AXIS_IN_TVALID & AXIS_IN_TREADY;
  assign w_frame_nx = r_frame_rem - 32'd1;
  assign w_pkt_nx   = (r_pkt_rem == 0) ? r_bpp - 32'd1 : r_pkt_rem - 32'd1;
  assign w_base_nx  = r_mode ? r_base + PATTERN_WIDTH'(LANES) : r_base;
  assign AXIS_IN_TREADY  = !reset & ((r_state == IDLE) | w_eof);
  assign start_of_frame  = w_acc;
  assign AXIS_OUT_TDATA  = r_data;
  assign AXIS_OUT_TVALID = r_valid;
  assign AXIS_OUT_TLAST  = r_last;
  assign AXIS_OUT_TUSER  = r_user;
  assign frames_sent     = r_frames;
  assign busy            = (r_state == RUN);
  // Frame FSM: seed load (including back-to-back reload at end of frame), beat advance and frame counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_user      <= 1'b0;
      r_mode      <= 1'b0;
      r_base      <= '0;
      r_data      <= '0;
      r_frame_rem <= '0;
      r_pkt_rem   <= '0;
      r_bpp       <= '0;
      r_frames    <= '0;
    end else begin
      if (w_eof) r_frames <= r_frames + 32'd1;
      if (w_acc) begin
        r_state     <= RUN;
        r_valid     <= 1'b1;
        r_user      <= 1'b1;
        r_mode      <= MODE;
        r_base      <= AXIS_IN_TDATA;
        r_data      <= gen(AXIS_IN_TDATA, MODE);
        r_frame_rem <= w_bpf - 32'd1;
        r_pkt_rem   <= w_bpp - 32'd1;
        r_bpp       <= w_bpp;
        r_last      <= (w_bpf == 32'd1) | (w_bpp == 32'd1);
      end else if (w_eof) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_user  <= 1'b0;
      end else if (w_hs) begin
        r_user      <= 1'b0;
        r_base      <= w_base_nx;
        r_data      <= gen(w_base_nx, r_mode);
        r_frame_rem <= w_frame_nx;
        r_pkt_rem   <= w_pkt_nx;
        r_last      <= (w_pkt_nx == 0) | (w_frame_nx == 0);
      end
    end
  end
endmodule

// File: tb/tb_simframe_pktgen.sv
// tb_simframe_pktgen: directed vector bench for simframe_pktgen
`timescale 1ns/1ps
module tb_simframe_pktgen;
  logic         clk = 0;
  logic         reset;
  logic [31:0]  frame_size, packet_size;
  logic         mode;
  logic [31:0]  in_tdata;
  logic         in_tvalid, in_tready;
  logic [511:0] out_tdata;
  logic         out_tvalid, out_tlast, out_tuser, out_tready;
  logic         sof, busy;
  logic [31:0]  frames;
  int checks = 0;
  int errors = 0;

  simframe_pktgen #(.PATTERN_WIDTH(32), .OUTPUT_WIDTH(512)) dut (
    .clk(clk), .reset(reset), .FRAME_SIZE(frame_size), .PACKET_SIZE(packet_size), .MODE(mode),
    .AXIS_IN_TDATA(in_tdata), .AXIS_IN_TVALID(in_tvalid), .AXIS_IN_TREADY(in_tready),
    .AXIS_OUT_TDATA(out_tdata), .AXIS_OUT_TVALID(out_tvalid), .AXIS_OUT_TLAST(out_tlast),
    .AXIS_OUT_TUSER(out_tuser), .AXIS_OUT_TREADY(out_tready), .start_of_frame(sof),
    .frames_sent(frames), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fsize;
    logic [31:0] psize;
    logic        mode;
    logic [31:0] seed;
    int          beats;
    logic [31:0] last_mask;
    logic        stall;
  } vec_t;
  vec_t tab[7];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_data(input logic [31:0] seed, input logic m, input int n);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < 16; k++)
      d[k*32 +: 32] = m ? seed + 32'(n * 16 + k) : seed;
    return d;
  endfunction

  task automatic run_frame(input vec_t v);
    int beat, cyc;
    logic [511:0] hd;
    logic hl, hu, held, rdy;
    logic [31:0] f0;
    f0 = frames;
    @(negedge clk);
    frame_size = v.fsize; packet_size = v.psize; mode = v.mode;
    in_tdata = v.seed; in_tvalid = 1; out_tready = 0;
    #1;
    chk("seed_ready", 512'(in_tready), 512'(1));
    chk("sof_strobe", 512'(sof), 512'(1));
    @(negedge clk);
    in_tvalid = 0;
    frame_size = 64; packet_size = 64; mode = ~v.mode;
    beat = 0; cyc = 0; held = 0; hd = '0; hl = 0; hu = 0;
    while (beat < v.beats && cyc < 400) begin
      rdy = v.stall ? 1'($urandom_range(1)) : 1'b1;
      out_tready = rdy;
      chk("tvalid_run", 512'(out_tvalid), 512'(1));
      chk("busy_run", 512'(busy), 512'(1));
      if (held) begin
        chk("stall_data", out_tdata, hd);
        chk("stall_last", 512'(out_tlast), 512'(hl));
        chk("stall_user", 512'(out_tuser), 512'(hu));
      end
      if (rdy) begin
        chk($sformatf("data_b%0d", beat), out_tdata, exp_data(v.seed, v.mode, beat));
        chk($sformatf("last_b%0d", beat), 512'(out_tlast), 512'(v.last_mask[beat]));
        chk($sformatf("user_b%0d", beat), 512'(out_tuser), 512'(beat == 0));
        beat++;
        held = 0;
      end else begin
        held = 1; hd = out_tdata; hl = out_tlast; hu = out_tuser;
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 400) chk("frame_timeout", 512'(cyc), 512'(0));
    out_tready = 1;
    chk("idle_valid", 512'(out_tvalid), 512'(0));
    chk("idle_busy", 512'(busy), 512'(0));
    chk("frames_inc", 512'(frames), 512'(f0 + 32'd1));
    chk("idle_ready", 512'(in_tready), 512'(1));
  endtask

  initial begin
    int sofs, nb, first_i, last_i;
    logic [3:0] users;
    tab[0] = '{256, 0,   1'b0, 32'hA5A5A5A5, 4,  32'h8,   1'b0};
    tab[1] = '{640, 192, 1'b0, 32'h12345678, 10, 32'h324, 1'b0};
    tab[2] = '{128, 0,   1'b1, 32'hFFFFFFF0, 2,  32'h2,   1'b0};
    tab[3] = '{10,  0,   1'b0, 32'hDEADBEEF, 1,  32'h1,   1'b0};
    tab[4] = '{640, 700, 1'b1, 32'h00001000, 10, 32'h200, 1'b0};
    tab[5] = '{200, 128, 1'b0, 32'hC0FFEE00, 3,  32'h6,   1'b0};
    tab[6] = '{640, 192, 1'b0, 32'h12345678, 10, 32'h324, 1'b1};
    reset = 1; frame_size = 0; packet_size = 0; mode = 0;
    in_tdata = 0; in_tvalid = 1; out_tready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 512'(in_tready), 512'(0));
    chk("rst_valid", 512'(out_tvalid), 512'(0));
    chk("rst_last", 512'(out_tlast), 512'(0));
    chk("rst_user", 512'(out_tuser), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_frames", 512'(frames), 512'(0));
    chk("rst_data", out_tdata, 512'(0));
    in_tvalid = 0;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 7; i++) run_frame(tab[i]);
    chk("frames_after_table", 512'(frames), 512'(7));

    // back-to-back seeds, held valid, no bubble
    sofs = 0; nb = 0; first_i = -1; last_i = -1; users = '0;
    frame_size = 128; packet_size = 0; mode = 0; out_tready = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_tdata = (sofs == 0) ? 32'h11111111 : 32'h22222222;
      in_tvalid = (sofs < 2);
      #1;
      if (sof) sofs++;
      if (out_tvalid && nb < 4) begin
        chk($sformatf("b2b_data%0d", nb), out_tdata, exp_data(nb < 2 ? 32'h11111111 : 32'h22222222, 1'b0, 0));
        chk($sformatf("b2b_last%0d", nb), 512'(out_tlast), 512'(nb % 2 == 1));
        users[nb] = out_tuser;
        if (first_i < 0) first_i = i;
        last_i = i;
        nb++;
      end
    end
    chk("b2b_sof_count", 512'(sofs), 512'(2));
    chk("b2b_beats", 512'(nb), 512'(4));
    chk("b2b_no_bubble", 512'(last_i - first_i), 512'(3));
    chk("b2b_user", 512'(users), 512'(4'b0101));
    chk("b2b_frames", 512'(frames), 512'(9));
    chk("b2b_idle", 512'(out_tvalid), 512'(0));

    // reset in the middle of a 10-beat frame
    @(negedge clk);
    frame_size = 640; packet_size = 0; mode = 0; in_tdata = 32'h5A5A5A5A; in_tvalid = 1;
    @(negedge clk);
    in_tvalid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_beat3_valid", 512'(out_tvalid), 512'(1));
    reset = 1;
    #1;
    chk("mid_rst_valid", 512'(out_tvalid), 512'(0));
    chk("mid_rst_last", 512'(out_tlast), 512'(0));
    chk("mid_rst_frames", 512'(frames), 512'(0));
    chk("mid_rst_in_ready", 512'(in_tready), 512'(0));
    @(negedge clk);
    reset = 0;
    run_frame(tab[0]);
    chk("post_rst_frames", 512'(frames), 512'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/simframe_pktgen.md
Name: simframe_pktgen

Overview:
- Parametrised successor frame generator for the bc_emu simulation path.
- Accepts one PATTERN_WIDTH seed word per frame on an AXI-Stream input and replicates it across an OUTPUT_WIDTH output stream for a whole frame.
- Adds two things a fixed-pattern generator lacks: per-packet TLAST framing inside each frame, and a selectable incrementing-pattern mode.
- Also marks frame-start beats on TUSER and counts completed frames.

Parameters:
- PATTERN_WIDTH, 32, seed/lane width in bits; one of 8,16,32,64,128,256,512; must divide OUTPUT_WIDTH.
- OUTPUT_WIDTH, 512, output data width in bits; OUT_BYTES = OUTPUT_WIDTH/8.
- LANES (localparam), OUTPUT_WIDTH/PATTERN_WIDTH, pattern lanes per beat.

Ports:
- clk  in  1  sole clock.
- reset  in  1  one clock; reset is asynchronous and active-high.
- FRAME_SIZE  in  32  frame length in bytes; sampled at frame start.
- PACKET_SIZE  in  32  packet length in bytes; sampled at frame start; 0 = whole frame is one packet.
- MODE  in  1  0 = constant replicate, 1 = incrementing lanes; sampled at frame start.
- AXIS_IN_TDATA  in  PATTERN_WIDTH  seed pattern.
- AXIS_IN_TVALID  in  1  seed valid.
- AXIS_IN_TREADY  out  1  seed accepted.
- AXIS_OUT_TDATA  out  OUTPUT_WIDTH  generated data.
- AXIS_OUT_TVALID  out  1  output valid.
- AXIS_OUT_TLAST  out  1  last beat of a packet.
- AXIS_OUT_TUSER  out  1  high on the first beat of each frame.
- AXIS_OUT_TREADY  in  1  downstream ready.
- start_of_frame  out  1  one-cycle strobe when a seed is accepted.
- frames_sent  out  32  completed frames since reset; wraps at 2^32.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (async assert, sync release)
  - state = IDLE; TVALID, TLAST, TUSER, busy = 0; frames_sent = 0; data registers = 0.
  - AXIS_IN_TREADY = 0 while reset is high.
- Derived counts (computed at seed acceptance)
  - beats_per_frame = FRAME_SIZE / OUT_BYTES, truncated; 0 is forced to 1.
  - beats_per_pkt = PACKET_SIZE / OUT_BYTES, truncated; 0, or a value >= beats_per_frame, means beats_per_frame.
- IDLE state
  - AXIS_IN_TREADY = 1.
  - On seed handshake: latch seed, MODE, and both counts.
  - Next cycle: TVALID = 1, TUSER = 1, state = RUN; latency is 1 cycle from seed to first beat.
- RUN state
  - Beat advances only on TVALID & TREADY.
  - TDATA, TLAST, TUSER are held stable while TVALID & !TREADY.
  - frame_rem and pkt_rem count down per beat.
  - TLAST = 1 when pkt_rem == 0 or frame_rem == 0. A short final packet, when the frame is not a multiple of the packet size, ends with TLAST.
  - pkt_rem reloads to beats_per_pkt-1 after each TLAST beat.
  - TUSER clears after the first beat handshake.
- Data
  - MODE 0: every lane = seed.
  - MODE 1: lane k of beat n = (seed + n*LANES + k) mod 2^PATTERN_WIDTH.
  - MODE 1 is implemented as a base register that advances by LANES per beat; no multipliers.
- End of frame (handshake with frame_rem == 0)
  - frames_sent increments.
  - AXIS_IN_TREADY = 1 combinationally in that cycle only.
  - If a seed is valid in the same cycle: relatch seed, MODE and counts; stay in RUN; next beat has TUSER = 1; no bubble.
  - Otherwise: TVALID = 0 and state = IDLE.
- In RUN, AXIS_IN_TREADY = 0 except at the end-of-frame handshake.
- start_of_frame = AXIS_IN_TVALID & AXIS_IN_TREADY.
- FRAME_SIZE, PACKET_SIZE and MODE changes mid-frame have no effect until the next seed.
- Reset mid-frame aborts immediately: no TLAST, and frames_sent is cleared.

Test Plan:
All cases use PATTERN_WIDTH=32, OUTPUT_WIDTH=512.
1. MODE 0, FRAME_SIZE=256, PACKET_SIZE=0, seed 0xA5A5A5A5, TREADY=1 -> 4 beats of all-0xA5 data; TLAST on beat 4 only; TUSER on beat 1; frames_sent=1; then IDLE.
2. FRAME_SIZE=640, PACKET_SIZE=192 -> 10 beats; TLAST on beats 3, 6, 9, 10.
3. MODE 1, seed 0xFFFFFFF0, FRAME_SIZE=128 -> beat 0 lanes 0xFFFFFFF0..0xFFFFFFFF; beat 1 lanes 0x00000000..0x0000000F (wrap).
4. Seed 0x11111111 then 0x22222222 held valid, FRAME_SIZE=128 -> 4 contiguous beats with no bubble; TUSER on beats 1 and 3; start_of_frame strobes twice; frames_sent=2.
5. Random TREADY stalls at 50% on case 2 -> TDATA, TLAST, TUSER stable through every stall; beat sequence identical to case 2.
6. FRAME_SIZE=10 -> exactly 1 beat with TLAST; reset asserted on beat 3 of a 10-beat frame -> TVALID=0 asynchronously, frames_sent=0, next seed starts a clean frame.
